// File: rtl/rf_wseq_pkg.sv
// Shared definitions for the RF write sequencer: per-entry lifecycle encoding.
package rf_wseq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_READY   = 2'd2,
        ST_WRITTEN = 2'd3
    } entry_state_t;

endpackage

// File: rtl/rf_write_sequencer.sv
// Reserves RF write names at issue, buffers out-of-order results and retires writes/frees in allocation order.
// Optional macro RF_WSEQ_BYPASS_EN: a result for the oldest waiting entry is written to the RF in the same cycle.
module rf_write_sequencer
    import rf_wseq_pkg::*;
#(
    parameter int addr_width = 5,
    parameter int data_width = 32,
    parameter int name_width = 2,
    parameter int numNames   = 2**name_width
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [addr_width-1:0] ISS_ADDR,
    input  logic                  ISS_E,
    output logic                  ISS_READY,
    output logic [name_width-1:0] ISS_NAME,
    input  logic [name_width-1:0] RES_NAME,
    input  logic [data_width-1:0] RES_DATA,
    input  logic                  RES_E,
    output logic                  RES_READY,
    output logic [addr_width-1:0] RF_ADDR_IN,
    output logic                  RF_ALLOC_E,
    input  logic                  RF_ALLOC_READY,
    output logic [name_width-1:0] RF_NAME_IN_1,
    output logic [data_width-1:0] RF_D_IN_1,
    output logic                  RF_WE_1,
    output logic [name_width-1:0] RF_W_F,
    output logic                  RF_WFE,
    input  logic                  RF_F_READY,
    output logic [name_width:0]   PENDING
);

    entry_state_t          ent_state     [numNames];
    entry_state_t          ent_state_nxt [numNames];
    logic [data_width-1:0] ent_buf       [numNames];

    logic [name_width-1:0] alloc_ptr;
    logic [name_width-1:0] wr_ptr;
    logic [name_width-1:0] free_ptr;
    logic [name_width:0]   pending;

    logic iss_fire;
    logic res_fire;
    logic wr_from_buf;
    logic wr_bypass;
    logic wr_fire;
    logic free_fire;

    assign ISS_READY  = RF_ALLOC_READY && (ent_state[alloc_ptr] == ST_IDLE);
    assign iss_fire   = ISS_E && ISS_READY;
    assign RF_ALLOC_E = iss_fire;
    assign RF_ADDR_IN = ISS_ADDR;
    assign ISS_NAME   = alloc_ptr;

    assign RES_READY  = (ent_state[RES_NAME] == ST_WAIT);
    assign res_fire   = RES_E && RES_READY;

    assign wr_from_buf = (ent_state[wr_ptr] == ST_READY);
`ifdef RF_WSEQ_BYPASS_EN
    // Only the head of the write order may bypass, so ordering is unchanged.
    assign wr_bypass = !wr_from_buf && res_fire && (RES_NAME == wr_ptr);
`else
    assign wr_bypass = 1'b0;
`endif
    assign wr_fire      = wr_from_buf || wr_bypass;
    assign RF_WE_1      = wr_fire;
    assign RF_NAME_IN_1 = wr_ptr;
    assign RF_D_IN_1    = wr_bypass ? RES_DATA : ent_buf[wr_ptr];

    assign RF_WFE    = (ent_state[free_ptr] == ST_WRITTEN);
    assign RF_W_F    = free_ptr;
    assign free_fire = RF_WFE && RF_F_READY;

    assign PENDING = pending;

    // The four events always target distinct entries, except a bypassed result
    // whose write transition is applied after its result transition.
    always_comb begin
        ent_state_nxt = ent_state;
        if (iss_fire)  ent_state_nxt[alloc_ptr] = ST_WAIT;
        if (res_fire)  ent_state_nxt[RES_NAME]  = ST_READY;
        if (wr_fire)   ent_state_nxt[wr_ptr]    = ST_WRITTEN;
        if (free_fire) ent_state_nxt[free_ptr]  = ST_IDLE;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < numNames; i++) ent_state[i] <= ST_IDLE;
            alloc_ptr <= '0;
            wr_ptr    <= '0;
            free_ptr  <= '0;
            pending   <= '0;
        end else begin
            ent_state <= ent_state_nxt;
            if (iss_fire)  alloc_ptr <= alloc_ptr + name_width'(1);
            if (wr_fire)   wr_ptr    <= wr_ptr + name_width'(1);
            if (free_fire) free_ptr  <= free_ptr + name_width'(1);
            case ({iss_fire, free_fire})
                2'b10:   pending <= pending + (name_width+1)'(1);
                2'b01:   pending <= pending - (name_width+1)'(1);
                default: pending <= pending;
            endcase
        end
    end

    // Result buffers carry data only and are not reset.
    always_ff @(posedge CLK) begin
        if (res_fire) ent_buf[RES_NAME] <= RES_DATA;
    end

endmodule

// File: doc/rf_write_sequencer.md
Name: rf_write_sequencer

Overview:
- Initiator-side driver for the bypass register file's write-reservation, write-data and write-free interfaces.
- Accepts destination addresses at issue and obtains a write name for each from the RF allocator.
- Buffers result data that arrives out of order, tagged by name.
- Drives the RF write port and free port strictly in allocation order. Sits between the pipeline's issue and writeback stages and the RF.

Parameters:
- addr_width, 5, architectural register address width
- data_width, 32, register data width
- name_width, 2, write-name width; must match the RF instance
- numNames, 2**name_width, number of in-flight write entries

Ports:
- CLK  input  1  clock
- RST  input  1  synchronous active-low reset
- ISS_ADDR  input  addr_width  destination address to reserve
- ISS_E  input  1  issue request
- ISS_READY  output  1  issue accepted this cycle if ISS_E
- ISS_NAME  output  name_width  name assigned to the issuing write
- RES_NAME  input  name_width  name of the arriving result
- RES_DATA  input  data_width  result data
- RES_E  input  1  result valid
- RES_READY  output  1  result accepted this cycle if RES_E
- RF_ADDR_IN  output  addr_width  RF allocation address
- RF_ALLOC_E  output  1  RF allocation enable
- RF_ALLOC_READY  input  1  RF can allocate
- RF_NAME_IN_1  output  name_width  RF write name
- RF_D_IN_1  output  data_width  RF write data
- RF_WE_1  output  1  RF write enable
- RF_W_F  output  name_width  RF name to free
- RF_WFE  output  1  RF free enable
- RF_F_READY  input  1  RF accepts free of RF_W_F
- PENDING  output  name_width+1  count of non-IDLE entries

Behaviour:
- Per-entry state: IDLE, WAIT (allocated, no data), READY (data buffered), WRITTEN (in RF, awaiting free). Each entry has a data_width buffer.
- Three pointers (alloc_ptr, wr_ptr, free_ptr) each wrap modulo numNames. All reset to 0.
- Reset (RST==0 at posedge): all entries IDLE, PENDING=0, pointers 0. RF_WE_1=0, RF_WFE=0 and RF_ALLOC_E=0 whenever ISS_E=0.
- Reset mid-operation discards all entries and buffered data. The RF must be reset in the same cycle.
- ISS_READY = RF_ALLOC_READY && state[alloc_ptr]==IDLE (combinational).
- RF_ALLOC_E = ISS_E && ISS_READY.
- RF_ADDR_IN = ISS_ADDR; ISS_NAME = alloc_ptr.
- On an accepted issue: entry goes to WAIT and alloc_ptr increments.
- Full condition: all entries non-IDLE, so ISS_READY=0.
- RES_READY = state[RES_NAME]==WAIT.
- On an accepted result: buffer[RES_NAME] takes RES_DATA and the entry goes to READY next cycle.
- A result for a non-WAIT name is dropped and has no effect.
- Write stage: if state[wr_ptr]==READY, drive RF_WE_1=1, RF_NAME_IN_1=wr_ptr, RF_D_IN_1=buffer[wr_ptr]. Entry goes to WRITTEN and wr_ptr increments. At most one write per cycle, always in order.
- Later READY entries wait behind an older WAIT entry.
- Free stage: RF_WFE=1 and RF_W_F=free_ptr when state[free_ptr]==WRITTEN.
- A free completes when RF_F_READY is also high: entry goes to IDLE and free_ptr increments.
- The earliest free is the cycle after that entry's write.
- Simultaneous issue, result, write and free in one cycle are all legal. They touch distinct entries by construction.
- An entry freed this cycle is reusable for issue next cycle.
- PENDING is updated each cycle: +1 on issue, -1 on free, unchanged if both occur.
- Latency (feature off): result accept to RF write is 1 cycle minimum; RF write to free is 1 cycle minimum.

Optional Feature:
- Macro: RF_WSEQ_BYPASS_EN.
- Defined: an accepted result with RES_NAME==wr_ptr and state WAIT is written to the RF in the same cycle (RF_D_IN_1=RES_DATA). The entry goes straight to WRITTEN and wr_ptr increments, giving 0-cycle write latency.
- Not defined: every result passes through the buffer (1 cycle).
- Both builds have identical ordering and free behaviour.

Decomposition:
- Shared package rf_wseq_pkg holds the 2-bit entry-state encoding (IDLE=0, WAIT=1, READY=2, WRITTEN=3).
- No sub-module is needed. Entries are a flat register array inside the block.

Test Plan:
- Reset, then issue addr 3, then result name 0 = 0xAB -> ISS_NAME=0. RF write of name 0 / 0xAB occurs 1 cycle after the result (0 with bypass). RF_WFE with W_F=0 follows the next cycle, and PENDING goes 1 -> 0.
- Issue 4 writes (names 0-3), then results in order 2,1,3,0 -> no RF write until name 0 arrives, then names 0,1,2,3 are written on consecutive cycles.
- Issue 4 without frees -> ISS_READY=0 on the 5th request. After free of name 0, the next issue gets name 0 (wrap).
- Hold RF_F_READY=0 for 3 cycles with name 0 WRITTEN -> RF_WFE stays high with W_F=0. Free occurs on the first cycle RF_F_READY=1.
- Result for an IDLE name 2 with data 0x55 -> RES_READY=0 and no state change.
- Assert RST=0 with 3 entries pending -> next cycle PENDING=0, ISS_NAME=0, RF_WE_1=0 and RF_WFE=0.
